// File: rtl/serial_adder_defs.sv
// Shared constants for the serial adder block:
// FSM state encodings and the default operand width.
package serial_adder_defs;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADD  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell used by the serial adder.
// Purely combinational.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one operand bit per cycle through a
// single full-adder cell, LSB first, with a start/done FSM.
module serial_adder_ctrl
  import serial_adder_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last;

  assign accept = (state == S_IDLE) && start;
  assign last   = (state == S_ADD) && (cnt == CW'(WIDTH - 1));

  fa_cell u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_ADD;
      S_ADD:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: operand shifters, carry, bit count, result
  always_ff @(posedge clock) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a_in;
      b_sr   <= b_in;
      sum_q  <= '0;
      carry  <= cin;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else if (state == S_ADD) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      sum_q <= {fa_s, sum_q[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      if (last) cout_q <= fa_c;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have port a_in  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port b_in  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port cin  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high in ADD and DONE states.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result, held until next accepted start.
REQ-011 SHALL have port cout  output  1  registered final carry, held with sum.

Function
REQ-012 SHALL implement FSM states IDLE, ADD, DONE.
REQ-013 SHALL, in IDLE with start=1, load A/B shift registers, load carry flop with cin, clear bit counter, clear sum and cout, and go to ADD.
REQ-014 SHALL, in IDLE with start=0, remain in IDLE with no state change.
REQ-015 SHALL, each ADD cycle, add A[0], B[0], carry through one 1-bit full-adder cell; shift A and B right by one; shift the sum bit into sum MSB (sum shifts right); update carry flop with cell carry.
REQ-016 SHALL increment the bit counter (width $clog2(WIDTH)) each ADD cycle and go to DONE on the cycle that processes bit WIDTH-1.
REQ-017 SHALL, in DONE, drive done=1 and cout=carry flop, and return to IDLE next cycle.
REQ-018 SHALL produce {cout,sum} = a_in + b_in + cin modulo 2^(WIDTH+1); no overflow flag.
REQ-019 SHALL assert done exactly WIDTH+1 cycles after the edge that accepted start.
REQ-020 SHALL ignore start while busy=1, including start during DONE; no queuing.
REQ-021 SHALL accept start on the cycle after DONE (back-to-back throughput one result per WIDTH+2 cycles).
REQ-022 SHALL ignore changes on a_in, b_in, cin after the accepting edge.
REQ-023 SHALL keep sum and cout stable from DONE until the next accepted start.
REQ-024 SHALL have no combinational path from any input to any output.

Reset
REQ-025 SHALL, with reset=1 at a rising edge, force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, shift registers=0.
REQ-026 SHALL give reset priority over start and over any in-progress addition; an aborted addition never asserts done.
REQ-027 SHALL accept start on the first edge with reset=0.

Structure
REQ-028 SHALL take state encodings (IDLE=2'b00, ADD=2'b01, DONE=2'b10) and default WIDTH from a shared constants file serial_adder_defs included by RTL and bench.
REQ-029 SHALL instantiate exactly one sub-module, fa_cell (a, b, cin -> sum, carry, purely combinational), for the per-bit add.
REQ-030 SHALL code the datapath registers and FSM in separate clocked processes with one combinational next-state process.

Verification
REQ-031 SHALL cover: WIDTH=8, a=0x00 b=0x00 cin=0, start one cycle -> done at cycle 9, sum=0x00, cout=0.
REQ-032 SHALL cover: a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1; then a=0xA5 b=0x5A cin=1 back-to-back on cycle after done -> sum=0x00, cout=1.
REQ-033 SHALL cover: start held high for 20 cycles with a=0x03 b=0x04 cin=0 -> two results 0x07 cout=0, done pulses exactly 10 cycles apart, inputs changed mid-op have no effect.
REQ-034 SHALL cover: reset asserted at cycle 4 of ADD -> next cycle busy=0, sum=0, cout=0, no done pulse; subsequent add 0x10+0x20 -> 0x30.
REQ-035 SHALL cover: WIDTH=3 exhaustive, all 128 (a,b,cin) combinations -> {cout,sum} equals a+b+cin, done latency 4 every time.
